// File: rtl/wash_phase_timer.sv
// -----------------------------------------------------------------------------
// wash_phase_timer
//
// Timing and programme scheduler that sits beside the auto_washing controller.
// It watches the controller's phase outputs, times the wash (soak+wash) and
// spin (drain+spin) phases against a programme-scaled duration, and raises
// cycle_timeout / spin_timeout back into the controller. Timing pauses while
// the door is open.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous, active-high reset
//   prog[1:0]      programme select (0 quick, 1 normal, 2 heavy, 3 = normal)
//   door           1 = closed; 0 = open (pauses timing)
//   soak, wash     controller wash-phase outputs
//   drain_valve    controller drain valve output
//   motor          controller motor output
//   done           controller done output; forces IDLE
//   cycle_timeout  wash phase expired (held until soak|wash falls)
//   spin_timeout   spin phase expired (held until done)
//   busy           scheduler not idle
//   prog_lat[1:0]  programme latched at the start of the current run
//   remaining      ticks left in the current timed phase, else 0
// -----------------------------------------------------------------------------
module wash_phase_timer #(
  parameter int PRESCALE  = 10,
  parameter int CNT_W     = 8,
  parameter int WASH_BASE = 16,
  parameter int SPIN_BASE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       prog,
  input  logic             door,
  input  logic             soak,
  input  logic             wash,
  input  logic             drain_valve,
  input  logic             motor,
  input  logic             done,
  output logic             cycle_timeout,
  output logic             spin_timeout,
  output logic             busy,
  output logic [1:0]       prog_lat,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WASH_T    = 3'd1,
    WASH_DONE = 3'd2,
    SPIN_T    = 3'd3,
    SPIN_DONE = 3'd4
  } state_t;

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW1   = CNT_W + 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [CNT_W:0]   WASH_B   = CW1'(WASH_BASE);
  localparam logic [CNT_W:0]   SPIN_B   = CW1'(SPIN_BASE);

  // Scale a base duration by programme. The extra top bit catches overflow of
  // the heavy (x2) programme so the result saturates instead of wrapping.
  function automatic logic [CNT_W-1:0] scale(input logic [CNT_W:0] base,
                                             input logic [1:0]     p);
    logic [CNT_W:0] full;
    case (p)
      2'd0:    full = base >> 1;
      2'd2:    full = base << 1;
      default: full = base;
    endcase
    if (full[CNT_W]) return '1;
    return full[CNT_W-1:0];
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [1:0]        prog_q, prog_d;
  // Sub-condition of WASH_DONE: wash has fallen, waiting for drain+motor.
  logic              wait_q, wait_d;

  logic              wash_req;
  logic              spin_req;
  logic              pre_wrap;
  logic [PRE_W-1:0]  pre_adv;
  logic [CNT_W-1:0]  cnt_adv;

  assign wash_req = soak | wash;
  assign spin_req = drain_valve & motor;

  // Prescaler and tick counter advance only while the door is closed.
  assign pre_wrap = (pre_q == PRE_LAST);
  assign pre_adv  = !door ? pre_q : (pre_wrap ? '0 : pre_q + PRE_W'(1));
  assign cnt_adv  = (door && pre_wrap && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      prog_q  <= '0;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      prog_q  <= prog_d;
      wait_q  <= wait_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first; any path that
    // left one unassigned would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    prog_d  = prog_q;
    wait_d  = wait_q;

    if (done) begin
      // done overrides every other transition, including run start from IDLE.
      state_d = IDLE;
      cnt_d   = '0;
      pre_d   = '0;
      wait_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wash_req) begin
            prog_d  = prog;
            cnt_d   = scale(WASH_B, prog);
            pre_d   = '0;
            state_d = WASH_T;
          end else if (spin_req) begin
            prog_d  = prog;
            cnt_d   = scale(SPIN_B, prog);
            pre_d   = '0;
            state_d = SPIN_T;
          end
        end

        WASH_T: begin
          if (!wash_req) begin
            state_d = IDLE;
            cnt_d   = '0;
            pre_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = WASH_DONE;
            wait_d  = 1'b0;
          end else begin
            pre_d = pre_adv;
            cnt_d = cnt_adv;
          end
        end

        WASH_DONE: begin
          // Timeout is held while wash is still asserted; after it falls the
          // spin phase starts as soon as drain+motor are both on.
          if (wait_q || !wash_req) begin
            if (spin_req) begin
              cnt_d   = scale(SPIN_B, prog_q);
              pre_d   = '0;
              wait_d  = 1'b0;
              state_d = SPIN_T;
            end else begin
              wait_d = 1'b1;
            end
          end
        end

        SPIN_T: begin
          if (!spin_req) begin
            state_d = IDLE;
            cnt_d   = '0;
            pre_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = SPIN_DONE;
          end else begin
            pre_d = pre_adv;
            cnt_d = cnt_adv;
          end
        end

        SPIN_DONE: begin
          // Only done (handled above) leaves this state.
          state_d = SPIN_DONE;
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          pre_d   = '0;
          wait_d  = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (Moore: registered state and counters only)
  // ---------------------------------------------------------------------------
  always_comb begin
    cycle_timeout = (state_q == WASH_DONE) && !wait_q;
    spin_timeout  = (state_q == SPIN_DONE);
    busy          = (state_q != IDLE);
    remaining     = (state_q == WASH_T || state_q == SPIN_T) ? cnt_q : '0;
  end

  assign prog_lat = prog_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// -----------------------------------------------------------------------------
// tb_wash_phase_timer
//
// Drives two instances from shared inputs: a main one (PRESCALE=2, CNT_W=8,
// WASH_BASE=4, SPIN_BASE=2) and a saturation one (CNT_W=3, WASH_BASE=6).
// A reference model tracks each run as a phase plus the number of door-closed
// clocks spent timing; remaining ticks and expiry follow from that count.
// -----------------------------------------------------------------------------
module tb_wash_phase_timer;

  localparam int P = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] prog = 2'd0;
  logic       door = 1'b1;
  logic       soak = 1'b0;
  logic       wash = 1'b0;
  logic       drain_valve = 1'b0;
  logic       motor = 1'b0;
  logic       done = 1'b0;

  logic       ct0, st0, busy0;
  logic [1:0] pl0;
  logic [7:0] rem0;
  logic       ct1, st1, busy1;
  logic [1:0] pl1;
  logic [2:0] rem1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wash_phase_timer #(.PRESCALE(P), .CNT_W(8), .WASH_BASE(4), .SPIN_BASE(2)) dut (
    .clk(clk), .rst(rst), .prog(prog), .door(door), .soak(soak), .wash(wash),
    .drain_valve(drain_valve), .motor(motor), .done(done),
    .cycle_timeout(ct0), .spin_timeout(st0), .busy(busy0),
    .prog_lat(pl0), .remaining(rem0)
  );

  wash_phase_timer #(.PRESCALE(P), .CNT_W(3), .WASH_BASE(6), .SPIN_BASE(2)) dut_sat (
    .clk(clk), .rst(rst), .prog(prog), .door(door), .soak(soak), .wash(wash),
    .drain_valve(drain_valve), .motor(motor), .done(done),
    .cycle_timeout(ct1), .spin_timeout(st1), .busy(busy1),
    .prog_lat(pl1), .remaining(rem1)
  );

  wire [12:0] got0 = {ct0, st0, busy0, pl0, rem0};
  wire [7:0]  got1 = {ct1, st1, busy1, pl1, rem1};

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef enum int {PH_IDLE, PH_WASH, PH_WASH_HOLD, PH_WASH_WAIT, PH_SPIN, PH_SPIN_HOLD} ph_t;

  ph_t m_ph[2]     = '{PH_IDLE, PH_IDLE};
  int  m_closed[2] = '{0, 0};
  int  m_dur[2]    = '{0, 0};
  int  m_prog[2]   = '{0, 0};

  function automatic int wash_base(int i); return (i == 0) ? 4 : 6; endfunction
  function automatic int max_ticks(int i); return (i == 0) ? 255 : 7; endfunction

  function automatic int dur(int base, int p, int mx);
    int v;
    v = (p == 0) ? base / 2 : (p == 2) ? base * 2 : base;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step(int i);
    logic wr, sr;
    wr = soak | wash;
    sr = drain_valve & motor;
    if (rst) begin
      m_ph[i] = PH_IDLE; m_closed[i] = 0; m_prog[i] = 0;
    end else if (done) begin
      m_ph[i] = PH_IDLE;
    end else begin
      case (m_ph[i])
        PH_IDLE:
          if (wr) begin
            m_prog[i] = prog; m_dur[i] = dur(wash_base(i), prog, max_ticks(i));
            m_closed[i] = 0; m_ph[i] = PH_WASH;
          end else if (sr) begin
            m_prog[i] = prog; m_dur[i] = dur(2, prog, max_ticks(i));
            m_closed[i] = 0; m_ph[i] = PH_SPIN;
          end
        PH_WASH:
          if (!wr) m_ph[i] = PH_IDLE;
          else if (m_closed[i] >= m_dur[i] * P) m_ph[i] = PH_WASH_HOLD;
          else if (door) m_closed[i]++;
        PH_WASH_HOLD, PH_WASH_WAIT:
          if (m_ph[i] == PH_WASH_WAIT || !wr) begin
            if (sr) begin
              m_dur[i] = dur(2, m_prog[i], max_ticks(i));
              m_closed[i] = 0; m_ph[i] = PH_SPIN;
            end else m_ph[i] = PH_WASH_WAIT;
          end
        PH_SPIN:
          if (!sr) m_ph[i] = PH_IDLE;
          else if (m_closed[i] >= m_dur[i] * P) m_ph[i] = PH_SPIN_HOLD;
          else if (door) m_closed[i]++;
        default: ;
      endcase
    end
  endtask

  function automatic int exp_rem(int i);
    int r;
    if (m_ph[i] != PH_WASH && m_ph[i] != PH_SPIN) return 0;
    r = m_dur[i] - m_closed[i] / P;
    return (r < 0) ? 0 : r;
  endfunction

  function automatic logic [12:0] exp_main();
    return {m_ph[0] == PH_WASH_HOLD, m_ph[0] == PH_SPIN_HOLD, m_ph[0] != PH_IDLE,
            2'(m_prog[0]), 8'(exp_rem(0))};
  endfunction

  function automatic logic [7:0] exp_sat();
    return {m_ph[1] == PH_WASH_HOLD, m_ph[1] == PH_SPIN_HOLD, m_ph[1] != PH_IDLE,
            2'(m_prog[1]), 3'(exp_rem(1))};
  endfunction

  // One clock edge: model samples the same inputs as the DUTs, outputs are
  // observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic go_idle();
    soak = 0; wash = 0; drain_valve = 0; motor = 0; door = 1; rst = 0; done = 1;
    step();
    done = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1; prog = 2'd3; door = 1; soak = 1; wash = 1; drain_valve = 1; motor = 1; done = 1;
    step();
    vectors++;
    if (got0 !== 13'd0) begin
      miscompares++; $display("FAIL reset_outputs: got %h want 0", got0);
    end
    vectors++;
    if (got1 !== 8'd0) begin
      miscompares++; $display("FAIL reset_outputs_sat: got %h want 0", got1);
    end
    rst = 0; done = 0; wash = 0; drain_valve = 0; motor = 0; soak = 1;
    step();
    vectors++;
    if (busy0 !== 1'b1) begin
      miscompares++; $display("FAIL reset_release_busy: got %b want 1", busy0);
    end
    vectors++;
    if (got0 !== exp_main()) begin
      miscompares++; $display("FAIL reset_release_state: got %h want %h", got0, exp_main());
    end
    go_idle();
  endtask

  task automatic test_normal_run();
    int n;
    prog = 2'd1; door = 1; wash = 1;
    step();
    n = 0;
    while (ct0 !== 1'b1 && n < 40) begin step(); n++; end
    vectors++;
    if (n != 9) begin
      miscompares++; $display("FAIL normal_wash_latency: got %0d clocks want 9", n);
    end
    vectors++;
    if (got0 !== exp_main()) begin
      miscompares++; $display("FAIL normal_wash_expiry: got %h want %h", got0, exp_main());
    end
    wash = 0; drain_valve = 1; motor = 1;
    step();
    n = 0;
    while (st0 !== 1'b1 && n < 40) begin step(); n++; end
    vectors++;
    if (n != 5) begin
      miscompares++; $display("FAIL normal_spin_latency: got %0d clocks want 5", n);
    end
    done = 1;
    step();
    done = 0; drain_valve = 0; motor = 0;
    vectors++;
    if (got0[12:10] !== 3'b000 || rem0 !== 8'd0) begin
      miscompares++; $display("FAIL normal_done_idle: got %h want ct/st/busy/rem all 0", got0);
    end
  endtask

  task automatic test_prog_scaling();
    int plist[3] = '{0, 2, 3};
    int lat[3]   = '{5, 17, 9};
    int n;
    for (int t = 0; t < 3; t++) begin
      go_idle();
      prog = 2'(plist[t]); wash = 1;
      step();
      prog = ~prog;  // must be ignored for the rest of the run
      n = 0;
      while (ct0 !== 1'b1 && n < 40) begin step(); n++; end
      vectors++;
      if (n != lat[t]) begin
        miscompares++;
        $display("FAIL prog_scale_latency: prog %0d got %0d clocks want %0d", plist[t], n, lat[t]);
      end
      vectors++;
      if (pl0 !== 2'(plist[t])) begin
        miscompares++; $display("FAIL prog_lat_hold: got %0d want %0d", pl0, plist[t]);
      end
    end
    go_idle();
  endtask

  task automatic test_door_pause();
    int n;
    prog = 2'd1; door = 1; wash = 1;
    step();
    n = 0;
    repeat (2) begin step(); n++; end
    door = 0;
    repeat (3) begin
      step(); n++;
      vectors++;
      if (rem0 !== 8'd3) begin
        miscompares++; $display("FAIL door_pause_frozen: got %0d want 3", rem0);
      end
    end
    door = 1;
    while (ct0 !== 1'b1 && n < 40) begin step(); n++; end
    vectors++;
    if (n != 12) begin
      miscompares++; $display("FAIL door_pause_latency: got %0d clocks want 12", n);
    end
    go_idle();
  endtask

  task automatic test_abort();
    logic seen;
    prog = 2'd1; wash = 1;
    step();
    repeat (3) step();
    wash = 0;
    step();
    vectors++;
    if (busy0 !== 1'b0) begin
      miscompares++; $display("FAIL abort_idle: busy got %b want 0", busy0);
    end
    seen = 0;
    repeat (12) begin step(); if (ct0 === 1'b1) seen = 1; end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++; $display("FAIL abort_no_timeout: cycle_timeout seen %b want 0", seen);
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    int n;
    prog = 2'd2; wash = 1;
    step();
    repeat (3) step();
    rst = 1;
    step();
    rst = 0; prog = 2'd1;
    vectors++;
    if ({busy0, pl0, rem0} !== 11'd0) begin
      miscompares++; $display("FAIL reset_mid_clear: got %h want 0", {busy0, pl0, rem0});
    end
    step();
    n = 0;
    while (ct0 !== 1'b1 && n < 40) begin step(); n++; end
    vectors++;
    if (n != 9) begin
      miscompares++; $display("FAIL reset_mid_fresh_run: got %0d clocks want 9", n);
    end
    go_idle();
  endtask

  task automatic test_saturation();
    int n;
    prog = 2'd2; wash = 1;
    step();
    vectors++;
    if (rem1 !== 3'd7) begin
      miscompares++; $display("FAIL sat_duration: got %0d want 7", rem1);
    end
    n = 0;
    while (ct1 !== 1'b1 && n < 40) begin step(); n++; end
    vectors++;
    if (n != 15) begin
      miscompares++; $display("FAIL sat_latency: got %0d clocks want 15", n);
    end
    go_idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 299) == 0);
      done = ($urandom_range(0, 39) == 0);
      door = ($urandom_range(0, 7) != 0);
      prog = 2'($urandom);
      if ($urandom_range(0, 11) == 0) wash = ~wash;
      if ($urandom_range(0, 29) == 0) soak = ~soak;
      if ($urandom_range(0, 11) == 0) begin
        drain_valve = ~drain_valve;
        motor = drain_valve ^ ($urandom_range(0, 5) == 0);
      end
      step();
      vectors++;
      if (got0 !== exp_main()) begin
        miscompares++; $display("FAIL random_main: cycle %0d got %h want %h", c, got0, exp_main());
      end
      vectors++;
      if (got1 !== exp_sat()) begin
        miscompares++; $display("FAIL random_sat: cycle %0d got %h want %h", c, got1, exp_sat());
      end
    end
    rst = 0;
    go_idle();
  endtask

  initial begin
    test_reset();
    test_normal_run();
    test_prog_scaling();
    test_door_pause();
    test_abort();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
